// File: rtl/ram_sp_clr.sv
// Single-port synchronous RAM with a post-reset hardware clear sweep.
// Latency: 1 cycle read and write; ready rises DEPTH enabled cycles after reset.
// No backpressure: requests while ready=0 are dropped, and ce=0 freezes everything.
// Optional feature: define RAM_SP_CLR_PARITY_EN to add a stored even-parity bit per word.
module ram_sp_clr #(
  parameter int              DATA_W    = 16,
  parameter int              ADDR_W    = 6,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              enable,
  input  logic              r_w,
  input  logic [ADDR_W-1:0] add,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              ready,
  output logic              parity_err
);

  localparam int DEPTH = 1 << ADDR_W;
`ifdef RAM_SP_CLR_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] data_out_q;
  logic              data_valid_q;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [MEM_W-1:0]  mem_wd;
  logic              rd_en;

  logic [MEM_W-1:0]  mem [DEPTH];

  // Stored word format: data, plus the even-parity bit on top when enabled.
  function automatic logic [MEM_W-1:0] encode(input logic [DATA_W-1:0] d);
`ifdef RAM_SP_CLR_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  // Next-state logic: the sweep owns the write port in CLEAR, the user owns it in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_we  = 1'b0;
    mem_wa  = add;
    mem_wd  = encode(data_in);
    if (ce) begin
      case (state_q)
        CLEAR: begin
          mem_we = 1'b1;
          mem_wa = cnt_q;
          mem_wd = encode(CLEAR_VAL);
          cnt_d  = cnt_q + 1'b1;
          if (&cnt_q) state_d = RUN;
        end
        RUN: begin
          if (enable && r_w) mem_we = 1'b1;
        end
        default: state_d = CLEAR;
      endcase
    end
  end

  assign rd_en = ce & enable & ~r_w & (state_q == RUN);

  // FSM and sweep counter; reset always restarts the sweep at word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage array; contents survive reset, only the sweep rewrites them.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem[mem_wa] <= mem_wd;
  end

  // Registered read port and read strobe; data_out holds when no read is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      data_valid_q <= rd_en;
      if (rd_en) data_out_q <= mem[add][DATA_W-1:0];
    end
  end

`ifdef RAM_SP_CLR_PARITY_EN
  logic parity_err_q;

  // Parity check: XOR over data and stored parity is 0 for an intact word.
  always_ff @(posedge clk) begin
    if (rst) parity_err_q <= 1'b0;
    else     parity_err_q <= rd_en & (^mem[add]);
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign ready      = (state_q == RUN);

endmodule

// File: tb/tb_ram_sp_clr.sv
// Directed bench for ram_sp_clr: clear sweep timing, gating, reset, read/write.
module tb_ram_sp_clr;

  localparam int DW = 16;
  localparam int AW = 6;
  localparam logic [DW-1:0] CV = 16'hA5A5;

  logic          clk = 1'b0;
  logic          rst, ce, enable, r_w;
  logic [AW-1:0] add;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          data_valid, ready, parity_err;

  int n_chk  = 0;
  int n_fail = 0;

  ram_sp_clr #(.DATA_W(DW), .ADDR_W(AW), .CLEAR_VAL(CV)) dut (
    .clk(clk), .rst(rst), .ce(ce), .enable(enable), .r_w(r_w), .add(add),
    .data_in(data_in), .data_out(data_out), .data_valid(data_valid),
    .ready(ready), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // After the reset edge, count edges until ready; optionally drop ce for a
  // window and inject a write (cycle 10) and a read (cycle 11) during the sweep.
  task automatic wait_ready(input int lo_start, input int lo_len, input bit inject,
                            output int cycles, output bit dv_seen);
    cycles  = -1;
    dv_seen = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      ce     = (i >= lo_start && i < lo_start + lo_len) ? 1'b0 : 1'b1;
      enable = 1'b0;
      if (inject && i == 10) begin
        enable = 1'b1; r_w = 1'b1; add = 6'd5; data_in = 16'h1234;
      end
      if (inject && i == 11) begin
        enable = 1'b1; r_w = 1'b0; add = 6'd5;
      end
      tick();
      if (data_valid) dv_seen = 1'b1;
      if (ready) begin
        cycles = i;
        break;
      end
    end
    ce = 1'b1; enable = 1'b0;
  endtask

  // Issue a read and check it one edge later; enable is left high so
  // consecutive calls are back-to-back.
  task automatic do_read(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    enable = 1'b1; r_w = 1'b0; add = a;
    tick();
    check({tag, "_data"}, data_out, exp);
    check({tag, "_dv"}, data_valid, 1'b1);
    check({tag, "_perr"}, parity_err, 1'b0);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    enable = 1'b1; r_w = 1'b1; add = a; data_in = d;
    tick();
    check("wr_dv", data_valid, 1'b0);
  endtask

  int cyc;
  bit dvs;

  initial begin
    rst = 1'b1; ce = 1'b1; enable = 1'b0; r_w = 1'b0; add = '0; data_in = '0;

    // Reset state
    tick();
    check("rst_ready", ready, 1'b0);
    check("rst_dv", data_valid, 1'b0);
    check("rst_dout", data_out, 16'h0);
    check("rst_perr", parity_err, 1'b0);
    rst = 1'b0;

    // Clear sweep with requests injected while clearing
    wait_ready(1000, 0, 1'b1, cyc, dvs);
    check("sweep_cycles", cyc, 64);
    check("sweep_no_dv", dvs, 1'b0);

    // Back-to-back reads of cleared words; address 5 ignored the early write
    do_read("rd0", 6'd0, CV);
    do_read("rd31", 6'd31, CV);
    do_read("rd63", 6'd63, CV);
    do_read("rd5", 6'd5, CV);
    enable = 1'b0;
    tick();
    check("idle_dv", data_valid, 1'b0);
    check("idle_hold", data_out, CV);

    // Write then immediate read
    do_write(6'd63, 16'hBEEF);
    check("wr_hold", data_out, CV);
    do_read("rd63b", 6'd63, 16'hBEEF);
    enable = 1'b0;
    tick();
    check("dv_one_cycle", data_valid, 1'b0);

    // Distinct data at neighbouring words
    do_write(6'd2, 16'h1111);
    do_write(6'd3, 16'h8001);
    do_read("rd2", 6'd2, 16'h1111);
    do_read("rd3", 6'd3, 16'h8001);

    // ce gating on a read request: output frozen, no strobe
    ce = 1'b0; enable = 1'b1; r_w = 1'b0; add = 6'd63;
    tick();
    check("ce0_hold", data_out, 16'h8001);
    check("ce0_dv", data_valid, 1'b0);
    // ce gating on a write request: memory untouched
    r_w = 1'b1; add = 6'd2; data_in = 16'hDEAD;
    tick();
    ce = 1'b1;
    do_read("rd2_ce", 6'd2, 16'h1111);
    enable = 1'b0;

    // Sweep with ce low for 8 cycles
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_ready(20, 8, 1'b0, cyc, dvs);
    check("ce_sweep_cycles", cyc, 72);

    // Reset mid-sweep at cycle 30
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 29; i++) tick();
    check("mid_not_ready", ready, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_ready(1000, 0, 1'b0, cyc, dvs);
    check("restart_cycles", cyc, 64);
    do_read("rd63c", 6'd63, CV);
    do_read("rd2c", 6'd2, CV);

    // Reset during a RUN read
    rst = 1'b1; enable = 1'b1; r_w = 1'b0; add = 6'd63;
    tick();
    check("rst_run_dv", data_valid, 1'b0);
    check("rst_run_dout", data_out, 16'h0);
    check("rst_run_ready", ready, 1'b0);
    rst = 1'b0; enable = 1'b0;
    wait_ready(1000, 0, 1'b0, cyc, dvs);
    check("post_rst_cycles", cyc, 64);

`ifdef RAM_SP_CLR_PARITY_EN
    // Corrupt one stored data bit and read it back
    dut.mem[7][0] = ~dut.mem[7][0];
    enable = 1'b1; r_w = 1'b0; add = 6'd7;
    tick();
    check("perr_flag", parity_err, 1'b1);
    check("perr_dv", data_valid, 1'b1);
    add = 6'd8;
    tick();
    check("perr_clean", parity_err, 1'b0);
    enable = 1'b0;
    tick();
    check("perr_idle", parity_err, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
